// File: rtl/memory_bus_initiator.sv
// -----------------------------------------------------------------------------
// memory_bus_initiator
//
// Turns client requests (single byte/half/word reads and writes, or
// LINE_WORDS-beat read line fills) into pipelined memory bus beats. Bus
// responses come back to the client as one-cycle pulses.
//
// Handshakes:
//   - Client request: accepted on a rising edge where ReqValid && ReqReady.
//     ReqReady is high only in IDLE and never while Reset is high.
//   - Bus beat: accepted on a rising edge where MemoryBusStrobe &&
//     !MemoryBusStall. Address, width, data and direction hold while stalled.
//   - Bus completion: MemoryBusAcknowledge completes one beat. It is ignored
//     outside ACTIVE and when no beat is outstanding.
//   - Response: RespValid is a one-cycle pulse that the client must take.
//     There is no back-pressure.
//
// Ports:
//   Clock, Reset                 sole clock; synchronous active-high reset
//   ReqValid/ReqReady            request handshake
//   ReqWrite/ReqBurst/ReqWidth   request kind; width 00 byte, 01 half,
//                                10 word, 11 reserved
//   ReqAddress/ReqData           byte address, right-justified write data
//   RespValid/RespData           response pulse and read data (0 for writes)
//   RespLast/RespError           final response of request / error response
//   MemoryBus*                   initiator side of the pipelined memory bus
//   DebugState                   current FSM state (0 IDLE, 1 ACTIVE, 2 ERROR)
// -----------------------------------------------------------------------------
module memory_bus_initiator #(
   parameter int LINE_WORDS = 4,
   parameter int TIMEOUT    = 255
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        ReqValid,
   output logic        ReqReady,
   input  logic        ReqWrite,
   input  logic        ReqBurst,
   input  logic [1:0]  ReqWidth,
   input  logic [31:0] ReqAddress,
   input  logic [31:0] ReqData,
   output logic        RespValid,
   output logic [31:0] RespData,
   output logic        RespLast,
   output logic        RespError,
   output logic [1:0]  MemoryDataWidth,
   output logic [31:0] MemoryAddress,
   output logic [31:0] MemoryDataIn,
   input  logic [31:0] MemoryDataOut,
   output logic        MemoryBusCycle,
   output logic        MemoryBusStrobe,
   output logic        MemoryBusReadWrite,
   input  logic        MemoryBusAcknowledge,
   input  logic        MemoryBusStall,
   output logic [1:0]  DebugState
);

   localparam int          TW        = $clog2(TIMEOUT + 1);
   localparam logic [31:0] LINE_MASK = 32'(LINE_WORDS * 4 - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_ERROR  = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [31:0]    addr_q, addr_d;
   logic [31:0]    data_q, data_d;
   logic [1:0]     width_q, width_d;
   logic           write_q, write_d;
   logic           burst_q, burst_d;
   logic [4:0]     issued_q, issued_d;
   logic [4:0]     acked_q, acked_d;
   logic [4:0]     outst_q, outst_d;
   logic [TW-1:0]  tmo_q, tmo_d;
   logic           resp_valid_q, resp_valid_d;
   logic [31:0]    resp_data_q, resp_data_d;
   logic           resp_last_q, resp_last_d;
   logic           resp_error_q, resp_error_d;

   logic [4:0] total_beats;
   logic       req_fire;
   logic       req_burst;
   logic       req_misaligned;
   logic       strobe;
   logic       beat_acc;
   logic       ack_ok;
   logic       final_ack;
   logic       tmo_hit;

   assign total_beats = burst_q ? 5'(LINE_WORDS) : 5'd1;
   assign req_fire    = ReqValid && ReqReady;
   // A burst is a read line fill only; ReqBurst on a write is a single write.
   assign req_burst   = ReqBurst && !ReqWrite;
   assign req_misaligned = (ReqWidth == 2'b11) ||
                           ((ReqWidth == 2'b01) && ReqAddress[0]) ||
                           ((ReqWidth == 2'b10) && (ReqAddress[1:0] != 2'b00));

   assign strobe   = (state_q == ST_ACTIVE) && (issued_q != total_beats);
   assign beat_acc = strobe && !MemoryBusStall;
   // Acks with nothing in flight are stray and must not create responses.
   assign ack_ok    = (state_q == ST_ACTIVE) && MemoryBusAcknowledge && (outst_q != 5'd0);
   assign final_ack = ack_ok && ((acked_q + 5'd1) == total_beats);
   assign tmo_hit   = (state_q == ST_ACTIVE) && (outst_q != 5'd0) && !ack_ok &&
                      (tmo_q == TW'(TIMEOUT - 1));

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q      <= ST_IDLE;
         addr_q       <= '0;
         data_q       <= '0;
         width_q      <= '0;
         write_q      <= 1'b0;
         burst_q      <= 1'b0;
         issued_q     <= '0;
         acked_q      <= '0;
         outst_q      <= '0;
         tmo_q        <= '0;
         resp_valid_q <= 1'b0;
         resp_data_q  <= '0;
         resp_last_q  <= 1'b0;
         resp_error_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         data_q       <= data_d;
         width_q      <= width_d;
         write_q      <= write_d;
         burst_q      <= burst_d;
         issued_q     <= issued_d;
         acked_q      <= acked_d;
         outst_q      <= outst_d;
         tmo_q        <= tmo_d;
         resp_valid_q <= resp_valid_d;
         resp_data_q  <= resp_data_d;
         resp_last_q  <= resp_last_d;
         resp_error_q <= resp_error_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      data_d       = data_q;
      width_d      = width_q;
      write_d      = write_q;
      burst_d      = burst_q;
      issued_d     = issued_q;
      acked_d      = acked_q;
      outst_d      = outst_q;
      tmo_d        = tmo_q;
      resp_valid_d = 1'b0;
      resp_data_d  = '0;
      resp_last_d  = 1'b0;
      resp_error_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (req_fire) begin
               if (req_misaligned) begin
                  // The error response is loaded here so it is visible
                  // during the single ERROR cycle.
                  state_d      = ST_ERROR;
                  resp_valid_d = 1'b1;
                  resp_error_d = 1'b1;
                  resp_last_d  = 1'b1;
               end else begin
                  state_d  = ST_ACTIVE;
                  addr_d   = req_burst ? (ReqAddress & ~LINE_MASK) : ReqAddress;
                  width_d  = req_burst ? 2'b10 : ReqWidth;
                  data_d   = ReqWrite ? ReqData : 32'd0;
                  write_d  = ReqWrite;
                  burst_d  = req_burst;
                  issued_d = '0;
                  acked_d  = '0;
                  outst_d  = '0;
                  tmo_d    = '0;
               end
            end
         end

         ST_ACTIVE: begin
            if (beat_acc) begin
               issued_d = issued_q + 5'd1;
               // Keep the last beat address on the bus instead of stepping
               // past the line.
               if ((issued_q + 5'd1) != total_beats) begin
                  addr_d = addr_q + 32'd4;
               end
            end
            // Accept and ack in the same cycle cancel out.
            outst_d = outst_q + {4'd0, beat_acc} - {4'd0, ack_ok};

            if (ack_ok) begin
               acked_d      = acked_q + 5'd1;
               tmo_d        = '0;
               resp_valid_d = 1'b1;
               resp_data_d  = write_q ? 32'd0 : MemoryDataOut;
               resp_last_d  = final_ack;
               if (final_ack) begin
                  state_d = ST_IDLE;
               end
            end else if (tmo_hit) begin
               state_d      = ST_ERROR;
               resp_valid_d = 1'b1;
               resp_error_d = 1'b1;
               resp_last_d  = 1'b1;
            end else if (outst_q != 5'd0) begin
               tmo_d = tmo_q + TW'(1);
            end
         end

         ST_ERROR: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign ReqReady           = (state_q == ST_IDLE) && !Reset;
   assign MemoryBusCycle     = (state_q == ST_ACTIVE);
   assign MemoryBusStrobe    = strobe;
   assign MemoryBusReadWrite = (state_q == ST_ACTIVE) && write_q;
   assign MemoryAddress      = addr_q;
   assign MemoryDataIn       = data_q;
   assign MemoryDataWidth    = width_q;
   assign RespValid          = resp_valid_q;
   assign RespData           = resp_data_q;
   assign RespLast           = resp_last_q;
   assign RespError          = resp_error_q;
   assign DebugState         = state_q;

endmodule

// File: tb/tb_memory_bus_initiator.sv
// -----------------------------------------------------------------------------
// tb_memory_bus_initiator
//
// Directed bench for memory_bus_initiator with LINE_WORDS=4 and TIMEOUT=8.
// Each scenario task drives its own stimulus and compares outputs inline
// against hand-computed values. Responses are collected on the falling edge
// into got_q and compared against exp_q.
// -----------------------------------------------------------------------------
module tb_memory_bus_initiator;

   localparam int LW  = 4;
   localparam int TMO = 8;

   logic        Clock = 1'b0;
   logic        Reset = 1'b1;
   logic        ReqValid = 1'b0;
   logic        ReqReady;
   logic        ReqWrite = 1'b0;
   logic        ReqBurst = 1'b0;
   logic [1:0]  ReqWidth = 2'b00;
   logic [31:0] ReqAddress = 32'd0;
   logic [31:0] ReqData = 32'd0;
   logic        RespValid;
   logic [31:0] RespData;
   logic        RespLast;
   logic        RespError;
   logic [1:0]  MemoryDataWidth;
   logic [31:0] MemoryAddress;
   logic [31:0] MemoryDataIn;
   logic [31:0] MemoryDataOut = 32'd0;
   logic        MemoryBusCycle;
   logic        MemoryBusStrobe;
   logic        MemoryBusReadWrite;
   logic        MemoryBusAcknowledge = 1'b0;
   logic        MemoryBusStall = 1'b0;
   logic [1:0]  DebugState;

   int pass_cnt = 0;
   int total_cnt = 0;
   int cyc_cnt = 0;

   // Response entries are {error, last, data}.
   logic [33:0] exp_q[$];
   logic [33:0] got_q[$];

   memory_bus_initiator #(
      .LINE_WORDS(LW),
      .TIMEOUT(TMO)
   ) dut (
      .Clock(Clock),
      .Reset(Reset),
      .ReqValid(ReqValid),
      .ReqReady(ReqReady),
      .ReqWrite(ReqWrite),
      .ReqBurst(ReqBurst),
      .ReqWidth(ReqWidth),
      .ReqAddress(ReqAddress),
      .ReqData(ReqData),
      .RespValid(RespValid),
      .RespData(RespData),
      .RespLast(RespLast),
      .RespError(RespError),
      .MemoryDataWidth(MemoryDataWidth),
      .MemoryAddress(MemoryAddress),
      .MemoryDataIn(MemoryDataIn),
      .MemoryDataOut(MemoryDataOut),
      .MemoryBusCycle(MemoryBusCycle),
      .MemoryBusStrobe(MemoryBusStrobe),
      .MemoryBusReadWrite(MemoryBusReadWrite),
      .MemoryBusAcknowledge(MemoryBusAcknowledge),
      .MemoryBusStall(MemoryBusStall),
      .DebugState(DebugState)
   );

   // ---------------- clock / monitor ----------------
   always #5 Clock = ~Clock;

   always @(negedge Clock) begin
      if (RespValid === 1'b1) got_q.push_back({RespError, RespLast, RespData});
      if (MemoryBusCycle === 1'b1) cyc_cnt++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic issue(input logic w, input logic b, input logic [1:0] wd,
                        input logic [31:0] a, input logic [31:0] d);
      total_cnt++;
      if (ReqReady !== 1'b1) $display("FAIL issue_ready: got %0b want 1", ReqReady);
      else pass_cnt++;
      ReqValid = 1'b1; ReqWrite = w; ReqBurst = b; ReqWidth = wd;
      ReqAddress = a; ReqData = d;
      cyc_cnt = 0;
      got_q.delete();
      tick();
      ReqValid = 1'b0; ReqWrite = 1'b0; ReqBurst = 1'b0; ReqWidth = 2'b00;
      ReqAddress = 32'd0; ReqData = 32'd0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      Reset = 1'b1;
      tick();
      tick();
      total_cnt++;
      if (ReqReady !== 1'b0) $display("FAIL rst_ready: got %0b want 0", ReqReady); else pass_cnt++;
      total_cnt++;
      if ({MemoryBusCycle, MemoryBusStrobe, MemoryBusReadWrite} !== 3'b000)
         $display("FAIL rst_bus: got %b want 000", {MemoryBusCycle, MemoryBusStrobe, MemoryBusReadWrite});
      else pass_cnt++;
      total_cnt++;
      if ({RespValid, RespLast, RespError} !== 3'b000)
         $display("FAIL rst_resp: got %b want 000", {RespValid, RespLast, RespError});
      else pass_cnt++;
      total_cnt++;
      if ({MemoryAddress, MemoryDataIn, RespData, MemoryDataWidth} !== 98'd0)
         $display("FAIL rst_data: addr %h din %h rdata %h width %b want all 0",
                  MemoryAddress, MemoryDataIn, RespData, MemoryDataWidth);
      else pass_cnt++;
      total_cnt++;
      if (DebugState !== 2'd0) $display("FAIL rst_state: got %0d want 0", DebugState); else pass_cnt++;
      Reset = 1'b0;
      #1;
      total_cnt++;
      if (ReqReady !== 1'b1) $display("FAIL rst_ready_after: got %0b want 1", ReqReady); else pass_cnt++;
      tick();
   endtask

   task automatic do_single_read(input logic [31:0] a, input logic [31:0] d);
      issue(1'b0, 1'b0, 2'b10, a, 32'd0);
      total_cnt++;
      if ({MemoryBusCycle, MemoryBusStrobe, MemoryBusReadWrite} !== 3'b110)
         $display("FAIL rd_first_beat: got %b want 110", {MemoryBusCycle, MemoryBusStrobe, MemoryBusReadWrite});
      else pass_cnt++;
      total_cnt++;
      if (MemoryAddress !== a) $display("FAIL rd_addr: got %h want %h", MemoryAddress, a); else pass_cnt++;
      total_cnt++;
      if (MemoryDataWidth !== 2'b10) $display("FAIL rd_width: got %b want 10", MemoryDataWidth); else pass_cnt++;
      tick();
      total_cnt++;
      if ({MemoryBusCycle, MemoryBusStrobe} !== 2'b10)
         $display("FAIL rd_after_beat: got %b want 10", {MemoryBusCycle, MemoryBusStrobe});
      else pass_cnt++;
      tick();
      MemoryBusAcknowledge = 1'b1;
      MemoryDataOut = d;
      tick();
      MemoryBusAcknowledge = 1'b0;
      MemoryDataOut = 32'd0;
      total_cnt++;
      if ({RespValid, RespLast, RespError} !== 3'b110)
         $display("FAIL rd_resp_flags: got %b want 110", {RespValid, RespLast, RespError});
      else pass_cnt++;
      total_cnt++;
      if (RespData !== d) $display("FAIL rd_resp_data: got %h want %h", RespData, d); else pass_cnt++;
      total_cnt++;
      if ({MemoryBusCycle, ReqReady} !== 2'b01)
         $display("FAIL rd_done: cycle/ready got %b want 01", {MemoryBusCycle, ReqReady});
      else pass_cnt++;
      tick();
      total_cnt++;
      if (got_q.size() != 1) $display("FAIL rd_resp_count: got %0d want 1", got_q.size()); else pass_cnt++;
      total_cnt++;
      if (cyc_cnt != 3) $display("FAIL rd_cycle_len: got %0d want 3", cyc_cnt); else pass_cnt++;
   endtask

   // Line fill with a bench model of beats issued / outstanding / acked.
   // rnd=0: stall on beat 2 for three cycles, ack whenever a beat is in flight.
   // rnd=1: random stall and ack (stray acks included); a long wait forces an
   //        ack so the timeout never fires.
   task automatic run_burst(input logic [31:0] a, input bit rnd);
      int issued, outst, acked, wait_c, stall_cnt, n;
      logic [31:0] base;
      issued = 0; outst = 0; acked = 0; wait_c = 0; stall_cnt = 0;
      base = a & ~32'(LW * 4 - 1);
      exp_q.delete();
      issue(1'b0, 1'b1, 2'b10, a, 32'd0);
      for (int cyc = 0; cyc < 200 && acked < LW; cyc++) begin
         logic st, ak, acc, ackv;
         logic [31:0] d;
         if (rnd) begin
            st = 1'($urandom_range(0, 1));
            ak = 1'($urandom_range(0, 1)) || (wait_c >= 4);
         end else begin
            st = (issued == 1) && (stall_cnt < 3);
            ak = (outst > 0);
         end
         d = $urandom;
         MemoryBusStall = st;
         MemoryBusAcknowledge = ak;
         MemoryDataOut = d;
         total_cnt++;
         if (MemoryBusStrobe !== (issued < LW))
            $display("FAIL burst_strobe: got %0b want %0b (beat %0d)", MemoryBusStrobe, issued < LW, issued);
         else pass_cnt++;
         if (issued < LW) begin
            total_cnt++;
            if (MemoryAddress !== base + 32'(issued * 4))
               $display("FAIL burst_addr: got %h want %h", MemoryAddress, base + 32'(issued * 4));
            else pass_cnt++;
         end
         acc  = (issued < LW) && !st;
         ackv = ak && (outst > 0);
         if (ackv) begin
            acked++;
            exp_q.push_back({1'b0, acked == LW, d});
            wait_c = 0;
         end else if (outst > 0) begin
            wait_c++;
         end
         if (!rnd && st) stall_cnt++;
         if (acc) issued++;
         outst = outst + int'(acc) - int'(ackv);
         tick();
      end
      MemoryBusStall = 1'b0;
      MemoryBusAcknowledge = 1'b0;
      MemoryDataOut = 32'd0;
      total_cnt++;
      if (acked != LW) $display("FAIL burst_bound: acked %0d want %0d", acked, LW); else pass_cnt++;
      total_cnt++;
      if ({RespValid, RespLast, MemoryBusCycle, ReqReady} !== 4'b1101)
         $display("FAIL burst_end: valid/last/cycle/ready got %b want 1101",
                  {RespValid, RespLast, MemoryBusCycle, ReqReady});
      else pass_cnt++;
      tick();
      total_cnt++;
      if (got_q.size() != exp_q.size())
         $display("FAIL burst_resp_count: got %0d want %0d", got_q.size(), exp_q.size());
      else pass_cnt++;
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         total_cnt++;
         if (got_q[i] !== exp_q[i])
            $display("FAIL burst_resp_%0d: got %h want %h", i, got_q[i], exp_q[i]);
         else pass_cnt++;
      end
   endtask

   task automatic test_misaligned();
      issue(1'b1, 1'b0, 2'b01, 32'h0000_0003, 32'h1234);
      total_cnt++;
      if ({MemoryBusCycle, MemoryBusStrobe} !== 2'b00)
         $display("FAIL mis_bus: got %b want 00", {MemoryBusCycle, MemoryBusStrobe});
      else pass_cnt++;
      total_cnt++;
      if ({RespValid, RespError, RespLast} !== 3'b111)
         $display("FAIL mis_resp: got %b want 111", {RespValid, RespError, RespLast});
      else pass_cnt++;
      total_cnt++;
      if (RespData !== 32'd0) $display("FAIL mis_data: got %h want 0", RespData); else pass_cnt++;
      total_cnt++;
      if ({ReqReady, DebugState} !== 3'b010)
         $display("FAIL mis_state: ready/state got %b want 010", {ReqReady, DebugState});
      else pass_cnt++;
      tick();
      total_cnt++;
      if ({RespValid, ReqReady, DebugState} !== 4'b0100)
         $display("FAIL mis_after: valid/ready/state got %b want 0100", {RespValid, ReqReady, DebugState});
      else pass_cnt++;
      issue(1'b0, 1'b0, 2'b11, 32'h0000_0000, 32'd0);
      total_cnt++;
      if ({MemoryBusCycle, RespValid, RespError} !== 3'b011)
         $display("FAIL reserved_width: cycle/valid/error got %b want 011", {MemoryBusCycle, RespValid, RespError});
      else pass_cnt++;
      tick();
      issue(1'b0, 1'b0, 2'b10, 32'h0000_0006, 32'd0);
      total_cnt++;
      if ({MemoryBusCycle, RespValid, RespError} !== 3'b011)
         $display("FAIL word_misaligned: cycle/valid/error got %b want 011", {MemoryBusCycle, RespValid, RespError});
      else pass_cnt++;
      tick();
   endtask

   task automatic test_word_write();
      issue(1'b1, 1'b0, 2'b10, 32'h0000_0008, 32'h0000_55AA);
      total_cnt++;
      if (MemoryDataIn !== 32'h0000_55AA) $display("FAIL wr_din: got %h want 000055aa", MemoryDataIn); else pass_cnt++;
      total_cnt++;
      if ({MemoryBusCycle, MemoryBusStrobe, MemoryBusReadWrite} !== 3'b111)
         $display("FAIL wr_bus: got %b want 111", {MemoryBusCycle, MemoryBusStrobe, MemoryBusReadWrite});
      else pass_cnt++;
      total_cnt++;
      if (MemoryAddress !== 32'h8) $display("FAIL wr_addr: got %h want 8", MemoryAddress); else pass_cnt++;
      tick();
      MemoryBusAcknowledge = 1'b1;
      MemoryDataOut = 32'hFFFF_FFFF;
      tick();
      MemoryBusAcknowledge = 1'b0;
      MemoryDataOut = 32'd0;
      total_cnt++;
      if ({RespValid, RespLast, RespError} !== 3'b110)
         $display("FAIL wr_resp_flags: got %b want 110", {RespValid, RespLast, RespError});
      else pass_cnt++;
      total_cnt++;
      if (RespData !== 32'd0) $display("FAIL wr_resp_data: got %h want 0", RespData); else pass_cnt++;
      tick();
   endtask

   task automatic test_byte_read();
      issue(1'b0, 1'b0, 2'b00, 32'h0000_0007, 32'd0);
      total_cnt++;
      if ({MemoryDataWidth, MemoryAddress} !== {2'b00, 32'h7})
         $display("FAIL byte_beat: width %b addr %h want 00 7", MemoryDataWidth, MemoryAddress);
      else pass_cnt++;
      // Ack while nothing is outstanding yet: must be ignored.
      MemoryBusAcknowledge = 1'b1;
      MemoryDataOut = 32'h0000_0011;
      tick();
      MemoryDataOut = 32'h0000_00A5;
      total_cnt++;
      if (RespValid !== 1'b0) $display("FAIL byte_stray_ack: got %0b want 0", RespValid); else pass_cnt++;
      tick();
      MemoryBusAcknowledge = 1'b0;
      MemoryDataOut = 32'd0;
      total_cnt++;
      if ({RespValid, RespLast, RespData} !== {2'b11, 32'h0000_00A5})
         $display("FAIL byte_resp: valid/last %b data %h want 11 000000a5", {RespValid, RespLast}, RespData);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (got_q.size() != 1) $display("FAIL byte_resp_count: got %0d want 1", got_q.size()); else pass_cnt++;
   endtask

   task automatic test_timeout();
      issue(1'b0, 1'b0, 2'b10, 32'h0000_0040, 32'd0);
      for (int i = 0; i < 40 && MemoryBusCycle === 1'b1; i++) tick();
      total_cnt++;
      if ({MemoryBusCycle, MemoryBusStrobe} !== 2'b00)
         $display("FAIL tmo_drop: cycle/strobe got %b want 00", {MemoryBusCycle, MemoryBusStrobe});
      else pass_cnt++;
      total_cnt++;
      if (cyc_cnt != TMO + 1) $display("FAIL tmo_cycle_len: got %0d want %0d", cyc_cnt, TMO + 1); else pass_cnt++;
      total_cnt++;
      if ({RespValid, RespError, RespLast, RespData} !== {3'b111, 32'd0})
         $display("FAIL tmo_resp: flags %b data %h want 111 0", {RespValid, RespError, RespLast}, RespData);
      else pass_cnt++;
      MemoryBusAcknowledge = 1'b1;
      tick();
      total_cnt++;
      if ({ReqReady, RespValid} !== 2'b10)
         $display("FAIL tmo_idle: ready/valid got %b want 10", {ReqReady, RespValid});
      else pass_cnt++;
      tick();
      MemoryBusAcknowledge = 1'b0;
      total_cnt++;
      if (RespValid !== 1'b0) $display("FAIL tmo_late_ack: got %0b want 0", RespValid); else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      issue(1'b0, 1'b1, 2'b10, 32'h0000_2000, 32'd0);
      tick();
      MemoryBusAcknowledge = 1'b1;
      MemoryDataOut = 32'h1111_1111;
      tick();
      MemoryDataOut = 32'h2222_2222;
      tick();
      MemoryBusAcknowledge = 1'b0;
      Reset = 1'b1;
      total_cnt++;
      if ({RespValid, RespLast, RespData} !== {2'b10, 32'h2222_2222})
         $display("FAIL rmid_second_resp: valid/last %b data %h want 10 22222222", {RespValid, RespLast}, RespData);
      else pass_cnt++;
      tick();
      Reset = 1'b0;
      #1;
      total_cnt++;
      if ({MemoryBusCycle, MemoryBusStrobe, RespValid, ReqReady} !== 4'b0001)
         $display("FAIL rmid_abandon: cycle/strobe/valid/ready got %b want 0001",
                  {MemoryBusCycle, MemoryBusStrobe, RespValid, ReqReady});
      else pass_cnt++;
      total_cnt++;
      if (got_q.size() != 2) $display("FAIL rmid_pre_count: got %0d want 2", got_q.size()); else pass_cnt++;
      got_q.delete();
      MemoryBusAcknowledge = 1'b1;
      MemoryDataOut = 32'h3333_3333;
      for (int i = 0; i < 3; i++) tick();
      MemoryBusAcknowledge = 1'b0;
      MemoryDataOut = 32'd0;
      tick();
      total_cnt++;
      if (got_q.size() != 0) $display("FAIL rmid_late_ack: got %0d responses want 0", got_q.size()); else pass_cnt++;
      do_single_read(32'h0000_0300, 32'hCAFE_F00D);
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      do_single_read(32'h0000_0100, 32'hDEAD_BEEF);
      run_burst(32'h0000_1234, 1'b0);
      test_misaligned();
      test_word_write();
      test_byte_read();
      test_timeout();
      test_reset_mid();
      run_burst(32'h0000_5678, 1'b1);
      run_burst(32'h0000_9ABC, 1'b1);
      run_burst(32'h0000_0010, 1'b1);
      tick();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
